// File: rtl/axi_pkg.sv
// Shared AXI constants, arbiter FSM states and requester indices.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [2:0] SIZE_WORD   = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam int unsigned REQ_DCACHE   = 0;
   localparam int unsigned REQ_ICACHE   = 1;
   localparam int unsigned REQ_PREFETCH = 2;

endpackage

// File: rtl/prio_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
module prio_encoder #(
   parameter int unsigned N   = 3,
   parameter int unsigned IDX = 2
) (
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant_oh,
   output logic [IDX-1:0] grant_idx,
   output logic           any_valid
);

   // Scan upward and keep only the first set bit.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && (grant_oh == '0)) begin
            grant_oh[i] = 1'b1;
            grant_idx   = IDX'(i);
         end
      end
   end

   assign any_valid = |req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Fixed-priority arbiter sharing one AXI read channel among N_REQ masters,
// one burst in flight, grant held from AR issue until the last R beat.
module axi_rd_arbiter
   import axi_pkg::*;
#(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned ID_W  = 4,
   parameter int unsigned LEN_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ-1:0][31:0]       req_addr,
   input  logic [N_REQ-1:0][LEN_W-1:0]  req_len,
   output logic [N_REQ-1:0]             acc,
   output logic [N_REQ-1:0]             beat_valid,
   output logic [31:0]                  beat_data,
   output logic                         beat_last,
   output logic                         beat_err,
   output logic                         busy,
   output logic [ID_W-1:0]              arid,
   output logic [31:0]                  araddr,
   output logic [LEN_W-1:0]             arlen,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic [1:0]                   arlock,
   output logic [3:0]                   arcache,
   output logic [2:0]                   arprot,
   output logic                         arvalid,
   input  logic                         arready,
   input  logic [ID_W-1:0]              rid,
   input  logic [31:0]                  rdata,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   output logic                         rready
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t             state, state_nxt;
   logic [N_REQ-1:0]   enc_oh;
   logic [IDX_W-1:0]   enc_idx;
   logic               any_req;
   logic [N_REQ-1:0]   grant_oh;
   logic [IDX_W-1:0]   grant_idx;
   logic [31:0]        addr_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   beat_cnt;
   logic               err_len;

   // Debug-only observables (rid is ignored with a single burst outstanding).
   logic               unused_dbg;
   assign unused_dbg = ^{rid, rresp[0], err_len};

   prio_encoder #(
      .N   (N_REQ),
      .IDX (IDX_W)
   ) u_prio (
      .req       (req),
      .grant_oh  (enc_oh),
      .grant_idx (enc_idx),
      .any_valid (any_req)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)          state_nxt = ADDR;
         ADDR:    if (arready)          state_nxt = DATA;
         DATA:    if (rvalid && rlast)  state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Grant/request latch, beat counter and sticky length-error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_oh  <= '0;
         grant_idx <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         err_len   <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            grant_oh  <= enc_oh;
            grant_idx <= enc_idx;
            addr_q    <= req_addr[enc_idx];
            len_q     <= req_len[enc_idx];
         end
         if (state == ADDR && arready) beat_cnt <= '0;
         if (state == DATA && rvalid) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            // beat_cnt is the index of this beat; rlast must coincide with index len.
            if (rlast != (beat_cnt == len_q)) err_len <= 1'b1;
         end
      end
   end

   // Handshake and beat-routing outputs.
   always_comb begin
      arvalid    = 1'b0;
      acc        = '0;
      rready     = 1'b0;
      beat_valid = '0;
      beat_data  = '0;
      beat_last  = 1'b0;
      beat_err   = 1'b0;
      case (state)
         ADDR: begin
            arvalid = 1'b1;
            if (arready) acc = grant_oh;
         end
         DATA: begin
            rready     = 1'b1;
            beat_valid = grant_oh & {N_REQ{rvalid}};
            beat_data  = rdata;
            beat_last  = rlast;
            beat_err   = rresp[1];
         end
         default: ;
      endcase
   end

   assign busy    = (state != IDLE);
   assign arid    = ID_W'(grant_idx);
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = SIZE_WORD;
   assign arburst = BURST_INCR;
   assign arlock  = '0;
   assign arcache = '0;
   assign arprot  = '0;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;

   logic               clk;
   logic               rst;
   logic [2:0]         req;
   logic [2:0][31:0]   req_addr;
   logic [2:0][7:0]    req_len;
   logic [2:0]         acc;
   logic [2:0]         beat_valid;
   logic [31:0]        beat_data;
   logic               beat_last;
   logic               beat_err;
   logic               busy;
   logic [3:0]         arid;
   logic [31:0]        araddr;
   logic [7:0]         arlen;
   logic [2:0]         arsize;
   logic [1:0]         arburst;
   logic [1:0]         arlock;
   logic [3:0]         arcache;
   logic [2:0]         arprot;
   logic               arvalid;
   logic               arready;
   logic [3:0]         rid;
   logic [31:0]        rdata;
   logic [1:0]         rresp;
   logic               rlast;
   logic               rvalid;
   logic               rready;

   int checks   = 0;
   int failures = 0;

   axi_rd_arbiter #(
      .N_REQ (3),
      .ID_W  (4),
      .LEN_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .acc        (acc),
      .beat_valid (beat_valid),
      .beat_data  (beat_data),
      .beat_last  (beat_last),
      .beat_err   (beat_err),
      .busy       (busy),
      .arid       (arid),
      .araddr     (araddr),
      .arlen      (arlen),
      .arsize     (arsize),
      .arburst    (arburst),
      .arlock     (arlock),
      .arcache    (arcache),
      .arprot     (arprot),
      .arvalid    (arvalid),
      .arready    (arready),
      .rid        (rid),
      .rdata      (rdata),
      .rresp      (rresp),
      .rlast      (rlast),
      .rvalid     (rvalid),
      .rready     (rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one burst for port p starting from an IDLE cycle with req[p] already set.
   // raise_at >= 0 asserts req[0] during that beat index.
   task automatic run_burst(input int p, input logic [31:0] addr, input logic [7:0] len,
                            input int ar_delay, input int nbeats, input int err_beat,
                            input int raise_at);
      logic [2:0] pmask;
      pmask = 3'b001 << p;
      #1;
      check("idle_busy", busy, 0);
      check("idle_arvalid", arvalid, 0);
      tick();
      #1;
      for (int w = 0; w < ar_delay; w++) begin
         check("ar_wait_arvalid", arvalid, 1);
         check("ar_wait_araddr", araddr, addr);
         check("ar_wait_arlen", arlen, len);
         check("ar_wait_arid", arid, p);
         check("ar_wait_acc", acc, 0);
         tick();
         #1;
      end
      arready = 1'b1;
      #1;
      check("ar_hs_arvalid", arvalid, 1);
      check("ar_hs_araddr", araddr, addr);
      check("ar_hs_arid", arid, p);
      check("ar_hs_acc", acc, pmask);
      tick();
      arready = 1'b0;
      req[p]  = 1'b0;
      #1;
      check("data_acc_once", acc, 0);
      for (int b = 0; b < nbeats; b++) begin
         rvalid = 1'b1;
         rdata  = addr + 32'(b * 4);
         rlast  = (b == nbeats - 1);
         rresp  = (b == err_beat) ? 2'b10 : 2'b00;
         if (b == raise_at) req[0] = 1'b1;
         #1;
         check("beat_valid", beat_valid, pmask);
         check("beat_data", beat_data, addr + 32'(b * 4));
         check("beat_last", beat_last, (b == nbeats - 1));
         check("beat_err", beat_err, (b == err_beat));
         check("rready", rready, 1);
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      #1;
      check("post_busy", busy, 0);
      check("post_rready", rready, 0);
      check("post_beat_valid", beat_valid, 0);
   endtask

   initial begin
      rst      = 1'b0;
      req      = '0;
      req_addr = '0;
      req_len  = '0;
      arready  = 1'b0;
      rid      = '0;
      rdata    = '0;
      rresp    = '0;
      rlast    = 1'b0;
      rvalid   = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_acc", acc, 0);
      check("rst_araddr", araddr, 0);
      check("rst_arid", arid, 0);
      check("rst_arsize", arsize, 2);
      check("rst_arburst", arburst, 1);
      check("rst_arlock", arlock, 0);
      rst = 1'b1;
      tick();

      // Single prefetch burst, arready after 2 cycles
      req[2] = 1'b1;
      req_addr[2] = 32'h1FC0_0040;
      req_len[2]  = 8'd15;
      run_burst(2, 32'h1FC0_0040, 8'd15, 2, 16, -1, -1);
      check("err_len_clean", dut.err_len, 0);
      tick();

      // Contention: all three at once
      req_addr[0] = 32'h0000_1000; req_len[0] = 8'd3;
      req_addr[1] = 32'h0000_2000; req_len[1] = 8'd1;
      req_addr[2] = 32'h0000_3000; req_len[2] = 8'd0;
      req = 3'b111;
      run_burst(0, 32'h0000_1000, 8'd3, 0, 4, -1, -1);
      run_burst(1, 32'h0000_2000, 8'd1, 1, 2, -1, -1);
      run_burst(2, 32'h0000_3000, 8'd0, 0, 1, -1, -1);
      tick();

      // Late high priority: no preemption
      req_addr[2] = 32'h0000_4000; req_len[2] = 8'd5;
      req_addr[0] = 32'h0000_5000; req_len[0] = 8'd2;
      req = 3'b100;
      run_burst(2, 32'h0000_4000, 8'd5, 0, 6, -1, 2);
      run_burst(0, 32'h0000_5000, 8'd2, 0, 3, -1, -1);
      tick();

      // Backpressure: arready low for 5 cycles
      req_addr[1] = 32'h0000_6000; req_len[1] = 8'd1;
      req = 3'b010;
      run_burst(1, 32'h0000_6000, 8'd1, 5, 2, -1, -1);
      check("err_len_still_clean", dut.err_len, 0);
      tick();

      // Length mismatch: len 15 but rlast on beat 8, error response on beat 3
      req_addr[0] = 32'h0000_7000; req_len[0] = 8'd15;
      req = 3'b001;
      run_burst(0, 32'h0000_7000, 8'd15, 0, 8, 3, -1);
      check("err_len_set", dut.err_len, 1);
      tick();

      // Reset during beat 5
      req_addr[0] = 32'h0000_8000; req_len[0] = 8'd7;
      req = 3'b001;
      tick();
      arready = 1'b1;
      tick();
      arready = 1'b0;
      req = '0;
      for (int b = 0; b < 4; b++) begin
         rvalid = 1'b1;
         rdata  = 32'h0000_8000 + 32'(b * 4);
         tick();
      end
      rdata = 32'h0000_8010;
      #1;
      check("rst_mid_beat_valid_pre", beat_valid, 3'b001);
      rst = 1'b0;
      #1;
      check("rst_mid_arvalid", arvalid, 0);
      check("rst_mid_rready", rready, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_beat_valid", beat_valid, 0);
      check("rst_mid_err_len", dut.err_len, 0);
      rvalid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      req_addr[1] = 32'h0000_9000; req_len[1] = 8'd2;
      req = 3'b010;
      run_burst(1, 32'h0000_9000, 8'd2, 1, 3, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel (AR/R) among three masters: data-cache refill (port 0), instruction-cache refill (port 1) and instruction prefetch buffer (port 2).
- Grants one burst at a time with fixed priority 0 > 1 > 2 and holds the grant from AR issue until the last R beat.
- Routes returned beats only to the granted master.
- Sits between the cache/prefetch blocks and the top-level AXI interface.

Parameters:
- N_REQ, 3, number of requesters; index order is priority order, 0 highest.
- ID_W, 4, AXI ID width.
- LEN_W, 8, AXI burst length field width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- req  in  N_REQ  per-master burst request, level; held until its acc pulse.
- req_addr  in  N_REQ x 32  per-master burst start address, aligned by the master.
- req_len  in  N_REQ x LEN_W  per-master arlen value (beats - 1).
- acc  out  N_REQ  one-cycle pulse on the AR handshake of that master's burst.
- beat_valid  out  N_REQ  R beat valid for that master.
- beat_data  out  32  R data, shared across masters.
- beat_last  out  1  last beat of the current burst.
- beat_err  out  1  rresp != OKAY on the current beat.
- busy  out  1  state != IDLE.
- arid  out  ID_W  index of the granted master.
- araddr  out  32
- arlen  out  LEN_W
- arsize  out  3  constant 2.
- arburst  out  2  constant INCR.
- arlock  out  2  constant 0.
- arcache  out  4  constant 0.
- arprot  out  3  constant 0.
- arvalid  out  1
- arready  in  1
- rid  in  ID_W
- rdata  in  32
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1

Behaviour:
- Reset values: state IDLE, grant 0, beat count 0. All outputs are 0 except the constant AR fields.
- IDLE:
  - If any req bit is set, latch grant = lowest set index, plus its addr and len, into registers. Go to ADDR next cycle.
  - Arbitration is combinational on req in IDLE only. No preemption after latching.
- ADDR:
  - arvalid = 1; araddr and arlen come from the latched registers; arid = grant.
  - On arvalid && arready: pulse acc[grant] for that cycle, clear beat count, go to DATA.
  - AR fields stay stable while arvalid is high and not accepted.
- DATA:
  - rready = 1.
  - beat_valid[grant] = rvalid; beat_data = rdata; beat_last = rlast; beat_err = rresp[1]. All combinational, zero latency.
  - Each rvalid beat increments the count (LEN_W bits).
  - On rvalid && rlast: go to IDLE.
  - If rlast arrives with count != latched len, or the count reaches len without rlast, set sticky err_len. err_len is an internal debug signal, cleared only by reset; it does not change the transitions.
  - rid mismatch against grant is ignored (single outstanding burst).
- Throughput: one burst in flight. The minimum turnaround is one IDLE cycle between bursts, so back-to-back grants are at least 1 cycle apart.
- Simultaneous requests in IDLE: the highest priority wins. Losers keep req asserted and are served in later IDLE cycles.
- A master dropping req during ADDR is illegal; the arbiter still completes the burst and beats are still presented.
- arready in the same cycle arvalid rises: the handshake completes that cycle (acc pulse, DATA next).
- rvalid && rlast in the first DATA cycle: legal for len = 0.
- Reset asserted mid-burst: returns to IDLE asynchronously and all outputs deassert. The AXI slave is reset by the same signal.

Decomposition:
- Shared package axi_pkg:
  - BURST_FIXED, BURST_INCR, BURST_WRAP, RESP_OKAY, SIZE_WORD constants.
  - state enum {IDLE, ADDR, DATA}.
  - Requester index constants REQ_DCACHE = 0, REQ_ICACHE = 1, REQ_PREFETCH = 2.
- One natural sub-module: prio_encoder (N_REQ in → one-hot grant plus index, any_valid), purely combinational and reusable by the write arbiter.

Test Plan:
- Single prefetch burst: req[2] = 1, addr 0x1FC0_0040, len 15; arready after 2 cycles; 16 R beats with rlast on the 16th → acc[2] pulses once; arid = 2; beat_valid[2] toggles 16 times; return to IDLE; busy falls the cycle after rlast.
- Contention: req = 3'b111 in the same cycle → grants in order 0, 1, 2; each acc pulses exactly once; no beat_valid on a non-granted port; each burst is separated by exactly 1 IDLE cycle.
- Late high priority: req[2] granted and in DATA, req[0] rises mid-burst → no preemption; req[0] is granted at the first IDLE after rlast.
- Backpressure: arready held 0 for 5 cycles → araddr, arlen and arid stable, arvalid high throughout; a single acc pulse at the handshake.
- Length mismatch: len 15, slave asserts rlast on beat 8 → FSM returns to IDLE; err_len = 1; beat_err = 1 on a beat with rresp = 2'b10.
- Reset mid-burst: rst = 0 during beat 5 → immediately arvalid = rready = busy = 0 and beat_valid = 0; after release, a new req[1] is served normally.
